// File: rtl/frame_draw_scheduler.sv
// frame_draw_scheduler
//   Per-frame owner of the VGA adapter plot port. A frame_tick starts a full
//   160x120 background sweep, after which each enabled client is handed the
//   port in index order (go pulse, then grant until done or cut off). The
//   scheduler then returns to idle.
//
// Ports
//   clock, resetn           system clock (posedge), async active-low reset
//   frame_tick              1-cycle pulse requesting a new frame
//   client_en               per-client enable, sampled when its turn comes
//   client_x/y/colour       packed per-client plot fields (8/7/3 bits each)
//   client_plot             per-client write strobe
//   client_done             per-client completion (level or pulse)
//   client_go               1-cycle start pulse to the client being served
//   client_grant            one-hot owner of the plot port
//   vga_x/y/colour/plot     registered plot port towards vga_adapter
//   frame_busy              high from frame accept until back in idle
//   overrun                 pulse: frame_tick seen while a frame is in flight
//   timeout                 pulse: a client held the port too long
module frame_draw_scheduler #(
  parameter int unsigned NUM_CLIENTS    = 3,
  parameter logic [2:0]  BG_COLOUR      = 3'b000,
  parameter int unsigned CLIENT_TIMEOUT = 4096
) (
  input  logic                     clock,
  input  logic                     resetn,
  input  logic                     frame_tick,
  input  logic [NUM_CLIENTS-1:0]   client_en,
  input  logic [8*NUM_CLIENTS-1:0] client_x,
  input  logic [7*NUM_CLIENTS-1:0] client_y,
  input  logic [3*NUM_CLIENTS-1:0] client_colour,
  input  logic [NUM_CLIENTS-1:0]   client_plot,
  input  logic [NUM_CLIENTS-1:0]   client_done,
  output logic [NUM_CLIENTS-1:0]   client_go,
  output logic [NUM_CLIENTS-1:0]   client_grant,
  output logic [7:0]               vga_x,
  output logic [6:0]               vga_y,
  output logic [2:0]               vga_colour,
  output logic                     vga_plot,
  output logic                     frame_busy,
  output logic                     overrun,
  output logic                     timeout
);

  // idx must also be able to hold NUM_CLIENTS (the "all clients done" value).
  localparam int unsigned IW = $clog2(NUM_CLIENTS + 1);
  localparam int unsigned TW = $clog2(CLIENT_TIMEOUT) + 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLEAR,
    S_SEL,
    S_GO,
    S_SERVE
  } state_t;

  state_t          state, state_n;
  logic [7:0]      x_cnt, x_n;
  logic [6:0]      y_cnt, y_n;
  logic [IW-1:0]   idx, idx_n;
  logic [TW-1:0]   timer, timer_n;

  logic [NUM_CLIENTS-1:0] go_n, grant_n;
  logic [7:0]             vx_n;
  logic [6:0]             vy_n;
  logic [2:0]             vc_n;
  logic                   plot_n, busy_n, overrun_n, timeout_n;

  // Fields of the client currently addressed by idx.
  logic       sel_en, sel_plot, sel_done;
  logic [7:0] sel_x;
  logic [6:0] sel_y;
  logic [2:0] sel_col;

  always_comb begin
    sel_en   = 1'b0;
    sel_plot = 1'b0;
    sel_done = 1'b0;
    sel_x    = '0;
    sel_y    = '0;
    sel_col  = '0;
    for (int unsigned i = 0; i < NUM_CLIENTS; i++) begin
      if (idx == IW'(i)) begin
        sel_en   = client_en[i];
        sel_plot = client_plot[i];
        sel_done = client_done[i];
        sel_x    = client_x[8*i +: 8];
        sel_y    = client_y[7*i +: 7];
        sel_col  = client_colour[3*i +: 3];
      end
    end
  end

  always_comb begin
    state_n   = state;
    x_n       = x_cnt;
    y_n       = y_cnt;
    idx_n     = idx;
    timer_n   = timer;
    plot_n    = 1'b0;
    vx_n      = vga_x;
    vy_n      = vga_y;
    vc_n      = vga_colour;
    timeout_n = 1'b0;
    overrun_n = frame_tick && (state != S_IDLE);

    case (state)
      S_IDLE: begin
        if (frame_tick) begin
          state_n = S_CLEAR;
          x_n     = '0;
          y_n     = '0;
        end
      end

      S_CLEAR: begin
        plot_n = 1'b1;
        vx_n   = x_cnt;
        vy_n   = y_cnt;
        vc_n   = BG_COLOUR;
        if (x_cnt == 8'd159) begin
          x_n = '0;
          if (y_cnt == 7'd119) begin
            y_n     = '0;
            idx_n   = '0;
            state_n = S_SEL;
          end else begin
            y_n = y_cnt + 7'd1;
          end
        end else begin
          x_n = x_cnt + 8'd1;
        end
      end

      S_SEL: begin
        if (idx == IW'(NUM_CLIENTS)) begin
          state_n = S_IDLE;
        end else if (!sel_en) begin
          idx_n = idx + IW'(1);
        end else begin
          state_n = S_GO;
        end
      end

      S_GO: begin
        plot_n  = sel_plot;
        vx_n    = sel_x;
        vy_n    = sel_y;
        vc_n    = sel_col;
        timer_n = '0;
        state_n = S_SERVE;
      end

      S_SERVE: begin
        plot_n  = sel_plot;
        vx_n    = sel_x;
        vy_n    = sel_y;
        vc_n    = sel_col;
        timer_n = timer + TW'(1);
        // done wins over the timeout limit when both land on the same cycle.
        if (sel_done) begin
          idx_n   = idx + IW'(1);
          state_n = S_SEL;
        end else if (timer == TW'(CLIENT_TIMEOUT - 1)) begin
          timeout_n = 1'b1;
          idx_n     = idx + IW'(1);
          state_n   = S_SEL;
        end
      end

      default: state_n = S_IDLE;
    endcase

    // go/grant/busy are registered from the next state so they line up with
    // the cycle the FSM actually sits in GO/SERVE.
    busy_n  = (state_n != S_IDLE);
    go_n    = '0;
    grant_n = '0;
    for (int unsigned i = 0; i < NUM_CLIENTS; i++) begin
      if (idx_n == IW'(i)) begin
        go_n[i]    = (state_n == S_GO);
        grant_n[i] = (state_n == S_GO) || (state_n == S_SERVE);
      end
    end
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state        <= S_IDLE;
      x_cnt        <= '0;
      y_cnt        <= '0;
      idx          <= '0;
      timer        <= '0;
      client_go    <= '0;
      client_grant <= '0;
      vga_x        <= '0;
      vga_y        <= '0;
      vga_colour   <= '0;
      vga_plot     <= 1'b0;
      frame_busy   <= 1'b0;
      overrun      <= 1'b0;
      timeout      <= 1'b0;
    end else begin
      state        <= state_n;
      x_cnt        <= x_n;
      y_cnt        <= y_n;
      idx          <= idx_n;
      timer        <= timer_n;
      client_go    <= go_n;
      client_grant <= grant_n;
      vga_x        <= vx_n;
      vga_y        <= vy_n;
      vga_colour   <= vc_n;
      vga_plot     <= plot_n;
      frame_busy   <= busy_n;
      overrun      <= overrun_n;
      timeout      <= timeout_n;
    end
  end

endmodule

// File: tb/tb_frame_draw_scheduler.sv
// tb_frame_draw_scheduler
//   Directed frame sequence with randomized client plot traffic. Expected
//   outputs come from a frame timeline computed up front (clear window, then
//   per-client go/grant windows derived from enable, done delay and timeout).
module tb_frame_draw_scheduler;

  localparam int N   = 3;
  localparam int TO  = 16;
  localparam logic [2:0] BG = 3'b101;
  localparam int PIX = 160 * 120;

  typedef logic [8*N-1:0] cx_t;
  typedef logic [7*N-1:0] cy_t;
  typedef logic [3*N-1:0] cc_t;
  typedef logic [N-1:0]   cn_t;

  logic       clock;
  logic       resetn;
  logic       frame_tick;
  cn_t        client_en;
  cx_t        client_x;
  cy_t        client_y;
  cc_t        client_colour;
  cn_t        client_plot;
  cn_t        client_done;
  cn_t        client_go;
  cn_t        client_grant;
  logic [7:0] vga_x;
  logic [6:0] vga_y;
  logic [2:0] vga_colour;
  logic       vga_plot;
  logic       frame_busy;
  logic       overrun;
  logic       timeout;

  frame_draw_scheduler #(
    .NUM_CLIENTS    (N),
    .BG_COLOUR      (BG),
    .CLIENT_TIMEOUT (TO)
  ) dut (
    .clock         (clock),
    .resetn        (resetn),
    .frame_tick    (frame_tick),
    .client_en     (client_en),
    .client_x      (client_x),
    .client_y      (client_y),
    .client_colour (client_colour),
    .client_plot   (client_plot),
    .client_done   (client_done),
    .client_go     (client_go),
    .client_grant  (client_grant),
    .vga_x         (vga_x),
    .vga_y         (vga_y),
    .vga_colour    (vga_colour),
    .vga_plot      (vga_plot),
    .frame_busy    (frame_busy),
    .overrun       (overrun),
    .timeout       (timeout)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  // Frame timeline model
  bit fv = 0;
  int k0 = 0;
  int s_end = 0;
  int g_c [N];
  int e_c [N];
  bit to_c [N];
  int dly [N];
  int done_at [N];

  // Inputs driven during the previous cycle
  bit  p_tick;
  cn_t p_plot;
  cx_t p_x;
  cy_t p_y;
  cc_t p_col;

  // Expected held plot fields
  logic [7:0] ex;
  logic [6:0] ey;
  logic [2:0] ec;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      errors++;
      $error("FAIL %s cycle %0d: observed %0h expected %0h", tag, cyc, obs, exp_v);
    end
  endtask

  function automatic bit mbusy(input int c);
    return fv && (c >= k0) && (c <= s_end);
  endfunction

  task automatic plan_frame(input int start);
    int s;
    fv = 1;
    k0 = start;
    s  = start + PIX;
    for (int i = 0; i < N; i++) begin
      g_c[i]  = -10;
      e_c[i]  = -20;
      to_c[i] = 0;
      if (!client_en[i]) begin
        s = s + 1;
      end else begin
        g_c[i] = s + 1;
        if (dly[i] != 0 && dly[i] <= TO) begin
          e_c[i] = g_c[i] + dly[i];
        end else begin
          e_c[i]  = g_c[i] + TO;
          to_c[i] = 1;
        end
        s = e_c[i] + 1;
      end
    end
    s_end = s;
  endtask

  task automatic cycle_step(input bit tick);
    bit  busy_e, ov_e, to_e, pl_e;
    cn_t go_e, gr_e;
    int  n;
    @(posedge clock);
    cyc++;
    #1;
    frame_tick    = tick;
    client_x      = cx_t'($urandom);
    client_y      = cy_t'($urandom);
    client_colour = cc_t'($urandom);
    client_plot   = cn_t'($urandom);
    for (int i = 0; i < N; i++) client_done[i] = (cyc == done_at[i]);
    if (tick && !mbusy(cyc)) plan_frame(cyc + 1);

    @(negedge clock);
    busy_e = mbusy(cyc);
    ov_e   = p_tick && mbusy(cyc - 1);
    go_e   = '0;
    gr_e   = '0;
    to_e   = 0;
    pl_e   = 0;
    if (fv) begin
      for (int i = 0; i < N; i++) begin
        go_e[i] = (cyc == g_c[i]);
        gr_e[i] = (cyc >= g_c[i]) && (cyc <= e_c[i]);
        if (to_c[i] && cyc == e_c[i] + 1) to_e = 1;
      end
    end
    if (fv && (cyc - 1 >= k0) && (cyc - 1 < k0 + PIX)) begin
      n    = cyc - 1 - k0;
      pl_e = 1;
      ex   = 8'(n % 160);
      ey   = 7'(n / 160);
      ec   = BG;
    end else if (fv) begin
      for (int i = 0; i < N; i++) begin
        if ((cyc - 1 >= g_c[i]) && (cyc - 1 <= e_c[i])) begin
          pl_e = p_plot[i];
          ex   = p_x[8*i +: 8];
          ey   = p_y[7*i +: 7];
          ec   = p_col[3*i +: 3];
        end
      end
    end

    chk("frame_busy", 32'(frame_busy), 32'(busy_e));
    chk("overrun", 32'(overrun), 32'(ov_e));
    chk("timeout", 32'(timeout), 32'(to_e));
    chk("client_go", 32'(client_go), 32'(go_e));
    chk("client_grant", 32'(client_grant), 32'(gr_e));
    chk("vga_plot", 32'(vga_plot), 32'(pl_e));
    chk("vga_x", 32'(vga_x), 32'(ex));
    chk("vga_y", 32'(vga_y), 32'(ey));
    chk("vga_colour", 32'(vga_colour), 32'(ec));

    // Behavioural clients: answer a go with a done pulse dly cycles later.
    for (int i = 0; i < N; i++) begin
      if (client_go[i] === 1'b1) done_at[i] = (dly[i] == 0) ? -1 : cyc + dly[i];
    end

    p_tick = tick;
    p_plot = client_plot;
    p_x    = client_x;
    p_y    = client_y;
    p_col  = client_colour;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_go"}, 32'(client_go), 32'(0));
    chk({tag, "_grant"}, 32'(client_grant), 32'(0));
    chk({tag, "_x"}, 32'(vga_x), 32'(0));
    chk({tag, "_y"}, 32'(vga_y), 32'(0));
    chk({tag, "_colour"}, 32'(vga_colour), 32'(0));
    chk({tag, "_plot"}, 32'(vga_plot), 32'(0));
    chk({tag, "_busy"}, 32'(frame_busy), 32'(0));
    chk({tag, "_overrun"}, 32'(overrun), 32'(0));
    chk({tag, "_timeout"}, 32'(timeout), 32'(0));
  endtask

  task automatic model_reset();
    fv     = 0;
    ex     = '0;
    ey     = '0;
    ec     = '0;
    p_tick = 0;
    p_plot = '0;
    for (int i = 0; i < N; i++) done_at[i] = -1;
  endtask

  // Asserts reset between clock edges; outputs must clear without an edge.
  task automatic async_reset();
    #2;
    frame_tick = 1'b0;
    resetn     = 1'b0;
    #1;
    chk_all_zero("async_rst");
    model_reset();
    repeat (3) cycle_step(1'b0);
    resetn = 1'b1;
  endtask

  task automatic run_frame(input int extra_off, input bit reentry_tick);
    int t0;
    t0 = cyc + 1;
    cycle_step(1'b1);
    for (int j = 0; j < 25000 && cyc < s_end + 4; j++) begin
      int nc;
      nc = cyc + 1;
      cycle_step((extra_off != 0 && nc == t0 + extra_off) || (reentry_tick && nc == s_end));
    end
    chk("frame_done_idle", 32'(frame_busy), 32'(0));
  endtask

  initial begin
    resetn        = 1'b0;
    frame_tick    = 1'b0;
    client_en     = '0;
    client_x      = '0;
    client_y      = '0;
    client_colour = '0;
    client_plot   = '0;
    client_done   = '0;
    for (int i = 0; i < N; i++) dly[i] = 0;
    model_reset();
    p_x   = '0;
    p_y   = '0;
    p_col = '0;

    repeat (3) @(posedge clock);
    @(negedge clock);
    chk_all_zero("reset");
    resetn = 1'b1;
    repeat (3) cycle_step(1'b0);

    // Reset in the middle of a clear sweep
    client_en = 3'b111;
    for (int i = 0; i < N; i++) dly[i] = 10;
    cycle_step(1'b1);
    repeat (80) cycle_step(1'b0);
    async_reset();
    repeat (5) cycle_step(1'b0);

    // Clear only, overrun 500 cycles in and again on the return to idle
    client_en = 3'b000;
    run_frame(500, 1'b1);
    repeat (3) cycle_step(1'b0);

    // All clients, each done 10 cycles after its go
    client_en = 3'b111;
    for (int i = 0; i < N; i++) dly[i] = 10;
    run_frame(0, 1'b0);
    repeat (3) cycle_step(1'b0);

    // Client 1 skipped; client 0 never done; client 2 done exactly at the limit
    client_en = 3'b101;
    dly[0] = 0;
    dly[1] = 5;
    dly[2] = TO;
    run_frame(0, 1'b0);
    repeat (5) cycle_step(1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
